mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Parametrised MEM stage for the pipelined core: replaces the single-cycle word-only data-memory stage with byte/half/word loads and stores, sign/zero load extension, misalignment detection, a configurable wait-state memory, and a registered MEM/WB output. It sits between the EX/MEM register and write-back. It stalls upstream through a ready/valid handshake and resolves branches (`pc_src`) on the accepting cycle.

## Interface
Parameters:
- `ADDR_W`, 9: byte-address width; memory depth is 2^(ADDR_W-2) 32-bit words.
- `WAIT_STATES`, 1: extra cycles per memory access, 0..15.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: EX/MEM holds a valid instruction.
- `in_ready` out 1: stage can accept this cycle.
- `branch`, `zero` in 1: branch instruction, ALU zero flag.
- `mem_read`, `mem_write` in 1: load / store.
- `size` in 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `unsigned_ld` in 1: zero-extend sub-word loads.
- `address` in ADDR_W: byte address, which is also the ALU result.
- `write_data` in 32: store data, right-aligned.
- `rd_in` in 5, `reg_write_in` in 1, `mem_to_reg_in` in 1: write-back controls.
- `pc_src` out 1: take branch.
- `wb_valid` out 1, `wb_data` out 32, `wb_rd` out 5, `wb_reg_write` out 1: MEM/WB register.
- `misaligned` out 1: one-cycle fault pulse, aligned with `wb_valid`.

## Operation
- Little-endian. Byte lane = `address[1:0]`. Word index = `address[ADDR_W-1:2]`.
- Accept means `in_valid & in_ready`.
- `pc_src` = accept & `branch` & `zero`, combinational.
- Misaligned access: half with `address[0]`=1, or word with `address[1:0]`≠0, on a load or store.
  - No memory access and no write.
  - 1-cycle completion with `misaligned`=1 and `wb_reg_write`=0.
- `mem_read & mem_write` together: the write wins and the access is handled as a store.
- Store lane merge:
  - sb writes the lane at `address[1:0]`.
  - sh writes lanes {1,0} or {3,2}.
  - sw writes all four lanes.
  - Unwritten lanes keep their value.
- Load: extract the lane(s), then sign-extend, or zero-extend if `unsigned_ld`.
- `wb_data` = load result if `mem_to_reg_in` and the access was a load; otherwise `address` zero-extended to 32 bits.
- `wb_rd` and `wb_reg_write` are `rd_in` and `reg_write_in` captured at accept. `wb_reg_write` is forced to 0 on a misaligned access.
- FSM:
  - IDLE:
    - `in_ready`=1.
    - On accept of an aligned load/store with WAIT_STATES>0: latch the request, load the counter with WAIT_STATES, go to WAIT.
    - Any other accept completes at the next edge.
  - WAIT:
    - `in_ready`=0 and the counter decrements each cycle.
    - On the edge where the counter reads 1: commit the store (or read the memory), load MEM/WB, return to IDLE.
- Memory contents are not cleared by reset.

## Timing
- Reset values: `wb_valid`, `wb_data`, `wb_rd`, `wb_reg_write`, `misaligned` are all 0. State is IDLE, so `in_ready`=1 once reset is asserted.
- Latency, accept to `wb_valid`:
  - Non-memory or misaligned: 1 cycle.
  - Aligned memory access: WAIT_STATES+1 cycles.
- `wb_valid` is high for exactly one cycle per completed instruction.
- With no accept, `wb_valid`=0 and the other MEM/WB fields hold their values.
- Throughput:
  - Non-memory ops: one per cycle, back-to-back.
  - Memory ops: one per WAIT_STATES+1 cycles.
- The store is committed only on the completion edge, so a load accepted afterwards sees the new data.
- Reset during WAIT aborts the access: no store is committed and no `wb_valid` is produced.
- `pc_src` is never asserted while in WAIT, even if `branch` and `zero` are held high.

## Structure
- Package `mem_stage_pkg`:
  - `SZ_BYTE`/`SZ_HALF`/`SZ_WORD` encodings.
  - FSM state encodings IDLE/WAIT.
  - A load-extract/extend function and a store lane-merge function.
- Sub-module `byte_lane_ram`: 2^(ADDR_W-2)×32 array with 4-bit byte write enable. Writes are synchronous and reads are combinational; the stage registers the read result.
- The top level contains the FSM, wait counter, request latch, alignment check and MEM/WB register.

## Test plan
Bench setup: `ADDR_W`=9, `WAIT_STATES`=2.
- **sw then lw:** sw 0xDEADBEEF @0x010, then lw @0x010 → `wb_data`=0xDEADBEEF. `wb_valid` comes 3 cycles after each accept, and `in_ready` is low for 2 cycles per access.
- **Byte store and loads:** sb 0x80 @0x013 over 0xDEADBEEF, then:
  - lb @0x013 → 0xFFFFFF80.
  - lbu @0x013 → 0x00000080.
  - lw @0x010 → 0x80ADBEEF.
- **Half loads:** lh @0x012 after the byte-store scenario → 0xFFFF80AD. Then lh @0x011 → `misaligned`=1 for one cycle with `wb_reg_write`=0, latency 1, and word 0x010 unchanged.
- **Branch resolution:**
  - `branch`=`zero`=1 with an IDLE accept → `pc_src`=1 in the same cycle.
  - Same inputs held during WAIT → `pc_src`=0 until re-accepted.
- **Reset mid-access:** reset in the second cycle of sw 0x12345678 @0x020, where 0x020 held 0xCAFEF00D → all wb outputs 0 and `in_ready`=1. A later lw @0x020 → 0xCAFEF00D.
- **ALU pass-through:** three consecutive ALU ops, e.g. `address`=0x1AB, `rd_in`=5, `reg_write_in`=1 → one `wb_valid` per cycle, first result `wb_data`=0x000001AB with `wb_rd`=5, and `in_ready` stays 1.

Source files
------------

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_pkg
// Description : Access-size and FSM encodings plus the lane helpers shared
//               by the MEM stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] data;
    } store_lanes_t;

    // Size 2'b11 falls into the word case everywhere below.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lane[0];
            default: return |lane;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic [1:0]  size,
                                                 input logic        is_unsigned);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: return is_unsigned ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_HALF: return is_unsigned ? {16'd0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    // Replicates the right-aligned store data across lanes; the byte enables
    // pick the lanes that change, so unselected lanes keep their old value.
    function automatic store_lanes_t store_merge(input logic [31:0] wdata,
                                                 input logic [1:0]  lane,
                                                 input logic [1:0]  size);
        store_lanes_t s;
        case (size)
            SZ_BYTE: begin
                s.data = {4{wdata[7:0]}};
                s.be   = 4'b0001 << lane;
            end
            SZ_HALF: begin
                s.data = {2{wdata[15:0]}};
                s.be   = lane[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                s.data = wdata;
                s.be   = 4'b1111;
            end
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_lane_ram.sv
`default_nettype none
// ============================================================================
// Module      : byte_lane_ram
// Description : Word-wide data memory with per-byte write enables,
//               synchronous write and combinational read.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_lane_ram #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic [3:0]        i_we,
    input  logic [ADDR_W-3:0] i_word_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    localparam int c_depth = 1 << (ADDR_W - 2);

    // Contents are intentionally left untouched by reset.
    logic [31:0] r_mem [c_depth];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_we[i]) begin
                r_mem[i_word_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_word_addr];

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : Pipelined MEM stage with sub-word loads/stores, misalignment
//               faults, wait-state memory and a registered MEM/WB output.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              branch,
    input  logic              zero,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       write_data,
    input  logic [4:0]        rd_in,
    input  logic              reg_write_in,
    input  logic              mem_to_reg_in,
    output logic              pc_src,
    output logic              wb_valid,
    output logic [31:0]       wb_data,
    output logic [4:0]        wb_rd,
    output logic              wb_reg_write,
    output logic              misaligned
);

    localparam logic [3:0] c_wait_load = 4'(WAIT_STATES);
    localparam logic       c_has_wait  = (WAIT_STATES > 0);

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [3:0]        r_count;
    logic [3:0]        w_count_nxt;
    logic              w_in_wait;
    logic              w_accept;
    logic              w_done;

    logic [ADDR_W-1:0] r_req_addr;
    logic [31:0]       r_req_wdata;
    logic [1:0]        r_req_size;
    logic              r_req_unsigned;
    logic              r_req_read;
    logic              r_req_write;
    logic [4:0]        r_req_rd;
    logic              r_req_reg_write;
    logic              r_req_mem_to_reg;

    logic [ADDR_W-1:0] w_src_addr;
    logic [31:0]       w_src_wdata;
    logic [1:0]        w_src_size;
    logic              w_src_unsigned;
    logic              w_src_read;
    logic              w_src_write;
    logic [4:0]        w_src_rd;
    logic              w_src_reg_write;
    logic              w_src_mem_to_reg;
    logic              w_src_is_load;
    logic              w_src_mem_op;
    logic              w_src_misalign;

    store_lanes_t      w_store;
    logic [3:0]        w_ram_we;
    logic [31:0]       w_ram_rdata;
    logic [31:0]       w_wb_data_nxt;

    assign w_in_wait = (r_state == ST_WAIT);
    assign in_ready  = ~w_in_wait;
    assign w_accept  = in_valid & in_ready;
    assign pc_src    = w_accept & branch & zero;

    // While waiting the latched request drives the datapath; in IDLE the live inputs do.
    assign w_src_addr       = w_in_wait ? r_req_addr       : address;
    assign w_src_wdata      = w_in_wait ? r_req_wdata      : write_data;
    assign w_src_size       = w_in_wait ? r_req_size       : size;
    assign w_src_unsigned   = w_in_wait ? r_req_unsigned   : unsigned_ld;
    assign w_src_read       = w_in_wait ? r_req_read       : mem_read;
    assign w_src_write      = w_in_wait ? r_req_write      : mem_write;
    assign w_src_rd         = w_in_wait ? r_req_rd         : rd_in;
    assign w_src_reg_write  = w_in_wait ? r_req_reg_write  : reg_write_in;
    assign w_src_mem_to_reg = w_in_wait ? r_req_mem_to_reg : mem_to_reg_in;

    assign w_src_is_load  = w_src_read & ~w_src_write;
    assign w_src_mem_op   = w_src_read | w_src_write;
    assign w_src_misalign = w_src_mem_op & is_misaligned(w_src_size, w_src_addr[1:0]);

    assign w_store  = store_merge(w_src_wdata, w_src_addr[1:0], w_src_size);
    assign w_ram_we = (w_done & w_src_write & ~w_src_misalign) ? w_store.be : 4'b0000;

    byte_lane_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk         (clk),
        .i_we        (w_ram_we),
        .i_word_addr (w_src_addr[ADDR_W-1:2]),
        .i_wdata     (w_store.data),
        .o_rdata     (w_ram_rdata)
    );

    assign w_wb_data_nxt = (w_src_mem_to_reg & w_src_is_load & ~w_src_misalign)
                         ? load_extract(w_ram_rdata, w_src_addr[1:0], w_src_size, w_src_unsigned)
                         : 32'(w_src_addr);

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (c_has_wait && w_src_mem_op && !w_src_misalign) begin
                        w_state_nxt = ST_WAIT;
                        w_count_nxt = c_wait_load;
                    end else begin
                        w_done = 1'b1;
                    end
                end
            end
            default: begin
                w_count_nxt = r_count - 4'd1;
                if (r_count == 4'd1) begin
                    w_state_nxt = ST_IDLE;
                    w_done      = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req_addr       <= '0;
            r_req_wdata      <= 32'd0;
            r_req_size       <= SZ_BYTE;
            r_req_unsigned   <= 1'b0;
            r_req_read       <= 1'b0;
            r_req_write      <= 1'b0;
            r_req_rd         <= 5'd0;
            r_req_reg_write  <= 1'b0;
            r_req_mem_to_reg <= 1'b0;
        end else if (w_accept) begin
            r_req_addr       <= address;
            r_req_wdata      <= write_data;
            r_req_size       <= size;
            r_req_unsigned   <= unsigned_ld;
            r_req_read       <= mem_read;
            r_req_write      <= mem_write;
            r_req_rd         <= rd_in;
            r_req_reg_write  <= reg_write_in;
            r_req_mem_to_reg <= mem_to_reg_in;
        end
    end

    // MEM/WB: payload fields only move on completion, otherwise they hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid     <= 1'b0;
            wb_data      <= 32'd0;
            wb_rd        <= 5'd0;
            wb_reg_write <= 1'b0;
            misaligned   <= 1'b0;
        end else begin
            wb_valid   <= w_done;
            misaligned <= w_done & w_src_misalign;
            if (w_done) begin
                wb_data      <= w_wb_data_nxt;
                wb_rd        <= w_src_rd;
                wb_reg_write <= w_src_reg_write & ~w_src_misalign;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Directed self-checking bench for mem_access_stage
//               (ADDR_W=9, WAIT_STATES=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    localparam logic [1:0] c_szb = 2'b00;
    localparam logic [1:0] c_szh = 2'b01;
    localparam logic [1:0] c_szw = 2'b10;

    logic        clk           = 1'b0;
    logic        reset         = 1'b1;
    logic        in_valid      = 1'b0;
    logic        in_ready;
    logic        branch        = 1'b0;
    logic        zero          = 1'b0;
    logic        mem_read      = 1'b0;
    logic        mem_write     = 1'b0;
    logic [1:0]  size          = 2'b00;
    logic        unsigned_ld   = 1'b0;
    logic [8:0]  address       = 9'd0;
    logic [31:0] write_data    = 32'd0;
    logic [4:0]  rd_in         = 5'd0;
    logic        reg_write_in  = 1'b0;
    logic        mem_to_reg_in = 1'b0;
    logic        pc_src;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        misaligned;

    int total = 0;
    int bad   = 0;
    int lat;
    int lows;

    always #5 clk = ~clk;

    mem_access_stage #(
        .ADDR_W      (9),
        .WAIT_STATES (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .branch        (branch),
        .zero          (zero),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .size          (size),
        .unsigned_ld   (unsigned_ld),
        .address       (address),
        .write_data    (write_data),
        .rd_in         (rd_in),
        .reg_write_in  (reg_write_in),
        .mem_to_reg_in (mem_to_reg_in),
        .pc_src        (pc_src),
        .wb_valid      (wb_valid),
        .wb_data       (wb_data),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .misaligned    (misaligned)
    );

    // Presents one instruction (caller is at posedge+1 in IDLE), then counts
    // cycles until wb_valid and how many of them had in_ready low.
    task automatic do_op(input logic rd_en, input logic wr_en, input logic [1:0] sz,
                         input logic uns, input logic [8:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd, input logic rw, input logic m2r,
                         output int o_lat, output int o_lows);
        mem_read = rd_en; mem_write = wr_en; size = sz; unsigned_ld = uns;
        address = addr; write_data = wd; rd_in = rd; reg_write_in = rw;
        mem_to_reg_in = m2r; branch = 1'b0; zero = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        o_lat = 1; o_lows = 0;
        while (!wb_valid && o_lat < 20) begin
            if (!in_ready) o_lows++;
            @(posedge clk); #1;
            o_lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rst_wb_valid got=%b want=0", wb_valid); end
        total++; if (wb_data !== 32'd0) begin bad++; $display("FAIL rst_wb_data got=%h want=0", wb_data); end
        total++; if (wb_rd !== 5'd0) begin bad++; $display("FAIL rst_wb_rd got=%0d want=0", wb_rd); end
        total++; if (wb_reg_write !== 1'b0) begin bad++; $display("FAIL rst_wb_reg_write got=%b want=0", wb_reg_write); end
        total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL rst_misaligned got=%b want=0", misaligned); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
        reset = 1'b0;
    endtask

    task automatic test_sw_lw();
        do_op(1'b0, 1'b1, c_szw, 1'b0, 9'h010, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, lat, lows);
        total++; if (lat != 3) begin bad++; $display("FAIL sw_latency got=%0d want=3", lat); end
        total++; if (lows != 2) begin bad++; $display("FAIL sw_ready_low got=%0d want=2", lows); end
        total++; if (wb_data !== 32'h00000010) begin bad++; $display("FAIL sw_wb_data got=%h want=00000010", wb_data); end
        do_op(1'b1, 1'b0, c_szw, 1'b0, 9'h010, 32'd0, 5'd3, 1'b1, 1'b1, lat, lows);
        total++; if (lat != 3) begin bad++; $display("FAIL lw_latency got=%0d want=3", lat); end
        total++; if (lows != 2) begin bad++; $display("FAIL lw_ready_low got=%0d want=2", lows); end
        total++; if (wb_data !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data got=%h want=deadbeef", wb_data); end
        total++; if (wb_rd !== 5'd3) begin bad++; $display("FAIL lw_rd got=%0d want=3", wb_rd); end
        total++; if (wb_reg_write !== 1'b1) begin bad++; $display("FAIL lw_reg_write got=%b want=1", wb_reg_write); end
        @(posedge clk); #1;
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL lw_valid_pulse got=%b want=0", wb_valid); end
        total++; if (wb_data !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data_hold got=%h want=deadbeef", wb_data); end
    endtask

    task automatic test_byte();
        do_op(1'b0, 1'b1, c_szb, 1'b0, 9'h013, 32'h12345680, 5'd0, 1'b0, 1'b0, lat, lows);
        total++; if (lat != 3) begin bad++; $display("FAIL sb_latency got=%0d want=3", lat); end
        do_op(1'b1, 1'b0, c_szb, 1'b0, 9'h013, 32'd0, 5'd1, 1'b1, 1'b1, lat, lows);
        total++; if (wb_data !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_13 got=%h want=ffffff80", wb_data); end
        do_op(1'b1, 1'b0, c_szb, 1'b1, 9'h013, 32'd0, 5'd1, 1'b1, 1'b1, lat, lows);
        total++; if (wb_data !== 32'h00000080) begin bad++; $display("FAIL lbu_13 got=%h want=00000080", wb_data); end
        do_op(1'b1, 1'b0, c_szw, 1'b0, 9'h010, 32'd0, 5'd1, 1'b1, 1'b1, lat, lows);
        total++; if (wb_data !== 32'h80ADBEEF) begin bad++; $display("FAIL lw_after_sb got=%h want=80adbeef", wb_data); end
        do_op(1'b1, 1'b0, c_szb, 1'b0, 9'h010, 32'd0, 5'd1, 1'b1, 1'b1, lat, lows);
        total++; if (wb_data !== 32'hFFFFFFEF) begin bad++; $display("FAIL lb_10 got=%h want=ffffffef", wb_data); end
        do_op(1'b1, 1'b0, c_szb, 1'b1, 9'h011, 32'd0, 5'd1, 1'b1, 1'b1, lat, lows);
        total++; if (wb_data !== 32'h000000BE) begin bad++; $display("FAIL lbu_11 got=%h want=000000be", wb_data); end
    endtask

    task automatic test_half();
        do_op(1'b1, 1'b0, c_szh, 1'b0, 9'h012, 32'd0, 5'd2, 1'b1, 1'b1, lat, lows);
        total++; if (wb_data !== 32'hFFFF80AD) begin bad++; $display("FAIL lh_12 got=%h want=ffff80ad", wb_data); end
        do_op(1'b1, 1'b0, c_szh, 1'b1, 9'h010, 32'd0, 5'd2, 1'b1, 1'b1, lat, lows);
        total++; if (wb_data !== 32'h0000BEEF) begin bad++; $display("FAIL lhu_10 got=%h want=0000beef", wb_data); end
        do_op(1'b1, 1'b0, c_szh, 1'b0, 9'h011, 32'd0, 5'd2, 1'b1, 1'b1, lat, lows);
        total++; if (lat != 1) begin bad++; $display("FAIL lh_mis_latency got=%0d want=1", lat); end
        total++; if (misaligned !== 1'b1) begin bad++; $display("FAIL lh_mis_flag got=%b want=1", misaligned); end
        total++; if (wb_reg_write !== 1'b0) begin bad++; $display("FAIL lh_mis_reg_write got=%b want=0", wb_reg_write); end
        @(posedge clk); #1;
        total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL lh_mis_pulse got=%b want=0", misaligned); end
        do_op(1'b0, 1'b1, c_szw, 1'b0, 9'h012, 32'h00000000, 5'd0, 1'b0, 1'b0, lat, lows);
        total++; if (lat != 1) begin bad++; $display("FAIL sw_mis_latency got=%0d want=1", lat); end
        total++; if (misaligned !== 1'b1) begin bad++; $display("FAIL sw_mis_flag got=%b want=1", misaligned); end
        do_op(1'b1, 1'b0, c_szw, 1'b0, 9'h010, 32'd0, 5'd2, 1'b1, 1'b1, lat, lows);
        total++; if (wb_data !== 32'h80ADBEEF) begin bad++; $display("FAIL word_after_mis got=%h want=80adbeef", wb_data); end
    endtask

    task automatic test_rw_conflict();
        do_op(1'b1, 1'b1, c_szw, 1'b0, 9'h030, 32'h11223344, 5'd4, 1'b0, 1'b1, lat, lows);
        total++; if (wb_data !== 32'h00000030) begin bad++; $display("FAIL rw_store_wb_data got=%h want=00000030", wb_data); end
        do_op(1'b0, 1'b1, c_szh, 1'b0, 9'h032, 32'hFFFFABCD, 5'd0, 1'b0, 1'b0, lat, lows);
        do_op(1'b1, 1'b0, c_szw, 1'b0, 9'h030, 32'd0, 5'd4, 1'b1, 1'b1, lat, lows);
        total++; if (wb_data !== 32'hABCD3344) begin bad++; $display("FAIL sh_merge got=%h want=abcd3344", wb_data); end
        do_op(1'b1, 1'b0, c_szh, 1'b1, 9'h032, 32'd0, 5'd4, 1'b1, 1'b1, lat, lows);
        total++; if (wb_data !== 32'h0000ABCD) begin bad++; $display("FAIL lhu_32 got=%h want=0000abcd", wb_data); end
    endtask

    task automatic test_branch();
        int hi;
        mem_read = 1'b0; mem_write = 1'b0; address = 9'h040; rd_in = 5'd2;
        reg_write_in = 1'b1; mem_to_reg_in = 1'b0; branch = 1'b1; zero = 1'b1; in_valid = 1'b1;
        #1;
        total++; if (pc_src !== 1'b1) begin bad++; $display("FAIL br_idle_pc_src got=%b want=1", pc_src); end
        @(posedge clk); #1;
        mem_read = 1'b1; size = c_szw; unsigned_ld = 1'b0; address = 9'h010; rd_in = 5'd4; mem_to_reg_in = 1'b1;
        #1;
        total++; if (pc_src !== 1'b1) begin bad++; $display("FAIL br_mem_accept_pc_src got=%b want=1", pc_src); end
        @(posedge clk); #1;
        hi = 0;
        for (int i = 0; i < 2; i++) begin
            if (pc_src !== 1'b0) hi++;
            @(posedge clk); #1;
        end
        total++; if (hi != 0) begin bad++; $display("FAIL br_wait_pc_src got=%0d want=0 cycles high", hi); end
        total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL br_load_done got=%b want=1", wb_valid); end
        total++; if (pc_src !== 1'b1) begin bad++; $display("FAIL br_reaccept_pc_src got=%b want=1", pc_src); end
        in_valid = 1'b0; mem_read = 1'b0; branch = 1'b0; zero = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int seen;
        do_op(1'b0, 1'b1, c_szw, 1'b0, 9'h020, 32'hCAFEF00D, 5'd9, 1'b0, 1'b0, lat, lows);
        mem_write = 1'b1; size = c_szw; address = 9'h020; write_data = 32'h12345678;
        rd_in = 5'd11; reg_write_in = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; mem_write = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_wb_valid got=%b want=0", wb_valid); end
        total++; if (wb_data !== 32'd0) begin bad++; $display("FAIL mid_rst_wb_data got=%h want=0", wb_data); end
        total++; if (wb_rd !== 5'd0) begin bad++; $display("FAIL mid_rst_wb_rd got=%0d want=0", wb_rd); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_in_ready got=%b want=1", in_ready); end
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (wb_valid) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL mid_rst_no_wb got=%0d want=0", seen); end
        do_op(1'b1, 1'b0, c_szw, 1'b0, 9'h020, 32'd0, 5'd6, 1'b1, 1'b1, lat, lows);
        total++; if (wb_data !== 32'hCAFEF00D) begin bad++; $display("FAIL mid_rst_mem got=%h want=cafef00d", wb_data); end
    endtask

    task automatic test_back_to_back();
        mem_read = 1'b0; mem_write = 1'b0; branch = 1'b0; zero = 1'b0;
        address = 9'h1AB; rd_in = 5'd5; reg_write_in = 1'b1; mem_to_reg_in = 1'b0; in_valid = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL alu1_in_ready got=%b want=1", in_ready); end
        @(posedge clk); #1;
        total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL alu1_valid got=%b want=1", wb_valid); end
        total++; if (wb_data !== 32'h000001AB) begin bad++; $display("FAIL alu1_data got=%h want=000001ab", wb_data); end
        total++; if (wb_rd !== 5'd5) begin bad++; $display("FAIL alu1_rd got=%0d want=5", wb_rd); end
        total++; if (wb_reg_write !== 1'b1) begin bad++; $display("FAIL alu1_reg_write got=%b want=1", wb_reg_write); end
        address = 9'h0C4; rd_in = 5'd6; reg_write_in = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL alu2_in_ready got=%b want=1", in_ready); end
        @(posedge clk); #1;
        total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL alu2_valid got=%b want=1", wb_valid); end
        total++; if (wb_data !== 32'h000000C4) begin bad++; $display("FAIL alu2_data got=%h want=000000c4", wb_data); end
        total++; if (wb_reg_write !== 1'b0) begin bad++; $display("FAIL alu2_reg_write got=%b want=0", wb_reg_write); end
        address = 9'h155; rd_in = 5'd7; reg_write_in = 1'b1; mem_to_reg_in = 1'b1;
        @(posedge clk); #1;
        total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL alu3_valid got=%b want=1", wb_valid); end
        total++; if (wb_data !== 32'h00000155) begin bad++; $display("FAIL alu3_data got=%h want=00000155", wb_data); end
        in_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL alu_idle_valid got=%b want=0", wb_valid); end
        total++; if (wb_rd !== 5'd7) begin bad++; $display("FAIL alu_idle_rd_hold got=%0d want=7", wb_rd); end
    endtask

    initial begin
        test_reset();
        test_sw_lw();
        test_byte();
        test_half();
        test_rw_conflict();
        test_branch();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
